// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready handshakes on both sides.
//
// The LOG_W shift layers (layer k moves the word by 2**k when len[k] is set) are spread over
// PIPE_STAGES register stages. Every stage register carries the partial result plus the
// operand's len, direction, mode and fill bit, so later stages can finish the shift. Each
// stage accepts a new operand whenever it is empty or its content moves on, so bubbles
// collapse and throughput is one operand per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; flushes every stage
//   in_valid   operand present
//   in_ready   operand accepted this cycle (0 while rst_n is low)
//   data       operand
//   len        shift amount, 0..WIDTH-1
//   direction  0 = left, 1 = right
//   mode       00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   out_valid  result present (last stage valid flag)
//   out_ready  consumer takes the result this cycle
//   out        result, straight from the last stage register
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LOG_W       = $clog2(WIDTH),
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [LOG_W-1:0] len,
  input  logic             direction,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] ModeArith  = 2'b01;
  localparam logic [1:0] ModeRotate = 2'b10;

  // Stage registers.
  logic [WIDTH-1:0] data_q [PIPE_STAGES];
  logic [WIDTH-1:0] data_d [PIPE_STAGES];
  logic [LOG_W-1:0] len_q  [PIPE_STAGES];
  logic [LOG_W-1:0] len_d  [PIPE_STAGES];
  logic             dir_q  [PIPE_STAGES];
  logic             dir_d  [PIPE_STAGES];
  logic [1:0]       mode_q [PIPE_STAGES];
  logic [1:0]       mode_d [PIPE_STAGES];
  logic             fill_q [PIPE_STAGES];
  logic             fill_d [PIPE_STAGES];
  logic             valid_q [PIPE_STAGES];
  logic             valid_d [PIPE_STAGES];

  // Inputs feeding each stage: the block inputs for stage 0, the previous register otherwise.
  logic [WIDTH-1:0] src_data  [PIPE_STAGES];
  logic [LOG_W-1:0] src_len   [PIPE_STAGES];
  logic             src_dir   [PIPE_STAGES];
  logic [1:0]       src_mode  [PIPE_STAGES];
  logic             src_fill  [PIPE_STAGES];
  logic             src_valid [PIPE_STAGES];

  // Stage s can take a new operand this cycle.
  logic             stage_rdy [PIPE_STAGES];

  // One mux layer: move x by 2**k, wrapping in rotate mode, else filling with fill.
  function automatic logic [WIDTH-1:0] shift_layer(input logic [WIDTH-1:0] x,
                                                   input int unsigned      k,
                                                   input logic             dir,
                                                   input logic [1:0]       md,
                                                   input logic             fill);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    int unsigned      amt;
    ones = '1;
    amt  = 32'd1 << k;
    if (md == ModeRotate) begin
      res = dir ? ((x >> amt) | (x << (WIDTH - amt)))
                : ((x << amt) | (x >> (WIDTH - amt)));
    end else if (dir) begin
      res = (x >> amt) | (fill ? ~(ones >> amt) : '0);
    end else begin
      // Fill is only ever set for right shifts, so left shifts always bring in zeros.
      res = x << amt;
    end
    return res;
  endfunction

  // Apply layers lo..hi-1 selected by l.
  function automatic logic [WIDTH-1:0] run_layers(input logic [WIDTH-1:0] x,
                                                  input logic [LOG_W-1:0] l,
                                                  input logic             dir,
                                                  input logic [1:0]       md,
                                                  input logic             fill,
                                                  input int unsigned      lo,
                                                  input int unsigned      hi);
    logic [WIDTH-1:0] acc;
    acc = x;
    for (int unsigned k = 0; k < LOG_W; k++) begin
      if (k >= lo && k < hi && l[k]) begin
        acc = shift_layer(acc, k, dir, md, fill);
      end
    end
    return acc;
  endfunction

  always_comb begin
    src_data[0]  = data;
    src_len[0]   = len;
    src_dir[0]   = direction;
    src_mode[0]  = mode;
    src_fill[0]  = (mode == ModeArith) && direction && data[WIDTH-1];
    src_valid[0] = in_valid;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      src_data[s]  = data_q[s-1];
      src_len[s]   = len_q[s-1];
      src_dir[s]   = dir_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_fill[s]  = fill_q[s-1];
      src_valid[s] = valid_q[s-1];
    end
  end

  // A stage is ready when the consumer pops or any stage from it to the end holds a bubble;
  // written without a self-referencing chain to keep the ready path a flat reduction.
  always_comb begin
    logic hole;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      hole = 1'b0;
      for (int t = s; t < PIPE_STAGES; t++) begin
        if (!valid_q[t]) begin
          hole = 1'b1;
        end
      end
      stage_rdy[s] = out_ready || hole;
    end
  end

  always_comb begin
    for (int s = 0; s < PIPE_STAGES; s++) begin
      data_d[s]  = data_q[s];
      len_d[s]   = len_q[s];
      dir_d[s]   = dir_q[s];
      mode_d[s]  = mode_q[s];
      fill_d[s]  = fill_q[s];
      valid_d[s] = valid_q[s];
      if (stage_rdy[s]) begin
        valid_d[s] = src_valid[s];
        len_d[s]   = src_len[s];
        dir_d[s]   = src_dir[s];
        mode_d[s]  = src_mode[s];
        fill_d[s]  = src_fill[s];
        data_d[s]  = run_layers(src_data[s], src_len[s], src_dir[s], src_mode[s], src_fill[s],
                                (s * LOG_W) / PIPE_STAGES, ((s + 1) * LOG_W) / PIPE_STAGES);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < PIPE_STAGES; s++) begin
      if (!rst_n) begin
        data_q[s]  <= '0;
        len_q[s]   <= '0;
        dir_q[s]   <= 1'b0;
        mode_q[s]  <= '0;
        fill_q[s]  <= 1'b0;
        valid_q[s] <= 1'b0;
      end else begin
        data_q[s]  <= data_d[s];
        len_q[s]   <= len_d[s];
        dir_q[s]   <= dir_d[s];
        mode_q[s]  <= mode_d[s];
        fill_q[s]  <= fill_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

  assign in_ready  = rst_n && stage_rdy[0];
  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out       = data_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH=32, PIPE_STAGES=2. Inputs are driven
// and outputs sampled on the falling edge; expected values are hand-computed constants.
module tb_pipelined_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data;
  logic [4:0]  len;
  logic        direction;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int n_tests;
  int n_fail;

  pipelined_barrel_shifter #(
    .WIDTH      (32),
    .PIPE_STAGES(2)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .len      (len),
    .direction(direction),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic dir,
                       input logic [1:0] md, input logic [4:0] ln);
    in_valid  = v;
    data      = d;
    direction = dir;
    mode      = md;
    len       = ln;
  endtask

  // Push one operand with out_ready=1 and check latency and value.
  task automatic run_vec(input string tag, input logic [31:0] d, input logic dir,
                         input logic [1:0] md, input logic [4:0] ln, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, d, dir, md, ln);
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 2'b00, 5'd0);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out"}, out, exp);
  endtask

  initial begin
    logic [31:0] ones;
    logic [31:0] exp;
    ones      = '1;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 2'b00, 5'd0);

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Directed modes: dir 0=left 1=right; mode 00 log, 01 arith, 10 rot, 11 reserved.
    run_vec("lsl4",       32'hFFFF_FFFF, 1'b0, 2'b00, 5'd4,  32'hFFFF_FFF0);
    run_vec("lsr31",      32'h8000_0000, 1'b1, 2'b00, 5'd31, 32'h0000_0001);
    run_vec("asr31",      32'h8000_0000, 1'b1, 2'b01, 5'd31, 32'hFFFF_FFFF);
    run_vec("rol1",       32'h8000_0001, 1'b0, 2'b10, 5'd1,  32'h0000_0003);
    run_vec("ror1",       32'h0000_0001, 1'b1, 2'b10, 5'd1,  32'h8000_0000);
    run_vec("rol0",       32'h1234_5678, 1'b0, 2'b10, 5'd0,  32'h1234_5678);
    run_vec("ror0",       32'h1234_5678, 1'b1, 2'b10, 5'd0,  32'h1234_5678);
    run_vec("asr0",       32'h8000_0000, 1'b1, 2'b01, 5'd0,  32'h8000_0000);
    run_vec("asr4",       32'h8000_0000, 1'b1, 2'b01, 5'd4,  32'hF800_0000);
    run_vec("asr30_pos",  32'h4000_0000, 1'b1, 2'b01, 5'd30, 32'h0000_0001);
    run_vec("asl4",       32'h8000_0001, 1'b0, 2'b01, 5'd4,  32'h0000_0010);
    run_vec("lsr4",       32'hF000_0000, 1'b1, 2'b00, 5'd4,  32'h0F00_0000);
    run_vec("rsv_r4",     32'h8000_0000, 1'b1, 2'b11, 5'd4,  32'h0800_0000);
    run_vec("rol8",       32'h1234_5678, 1'b0, 2'b10, 5'd8,  32'h3456_7812);
    run_vec("ror8",       32'h1234_5678, 1'b1, 2'b10, 5'd8,  32'h7812_3456);
    run_vec("ror21",      32'h0000_0003, 1'b1, 2'b10, 5'd21, 32'h0000_1800);

    // Back-to-back sweep: result k visible two negedges after it is driven.
    for (int cyc = 0; cyc < 35; cyc++) begin
      @(negedge clk);
      if (cyc < 32) begin
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 2'b00, 5'(cyc));
      end else begin
        drive(1'b0, 32'h0, 1'b0, 2'b00, 5'd0);
      end
      if (cyc < 32) begin
        #1;
        check($sformatf("sweep_in_ready%0d", cyc), 32'(in_ready), 32'd1);
      end
      if (cyc >= 2 && cyc < 34) begin
        exp = ones << (cyc - 2);
        check($sformatf("sweep_valid%0d", cyc - 2), 32'(out_valid), 32'd1);
        check($sformatf("sweep_out%0d", cyc - 2), out, exp);
      end
      if (cyc == 34) begin
        check("sweep_drained", 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: A=1<<1, B=1<<2, C=1<<3 with the consumer stalled.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 1'b0, 2'b00, 5'd1);
    #1;
    check("bp_accept_a", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h1, 1'b0, 2'b00, 5'd2);
    #1;
    check("bp_accept_b", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h1, 1'b0, 2'b00, 5'd3);
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_head_valid", 32'(out_valid), 32'd1);
    check("bp_head_out", out, 32'h2);
    @(negedge clk);
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_out_stable", out, 32'h2);
    check("bp_valid_stable", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_pop_push_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 2'b00, 5'd0);
    check("bp_res_b_valid", 32'(out_valid), 32'd1);
    check("bp_res_b", out, 32'h4);
    @(negedge clk);
    check("bp_res_c_valid", 32'(out_valid), 32'd1);
    check("bp_res_c", out, 32'h8);
    @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Reset mid-flight discards both in-flight operands.
    @(negedge clk);
    drive(1'b1, 32'h5, 1'b0, 2'b00, 5'd1);
    @(negedge clk);
    drive(1'b1, 32'h6, 1'b0, 2'b00, 5'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 2'b00, 5'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out", out, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mid_rst_no_valid%0d", i), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    run_vec("after_rst", 32'h0000_00F0, 1'b1, 2'b00, 5'd4, 32'h0000_000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
